// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller and its priority encoder.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  localparam int VEC_W          = 32;
  localparam int DEF_VEC_STRIDE = 4;
  localparam int DEF_TIMEOUT    = 500;

  // Width of a binary index over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scanning from the top down lets lower indices overwrite higher ones.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Prioritised, maskable interrupt controller with request/ack handshake,
// single-level service tracking and a service watchdog.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no request outstanding; arbitrate unmasked pending sources
//   REQ     | irq/irq_id held for the latched winner until irq_ack
//   SERVICE | handler running; wait for rti or watchdog expiry
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int NSRC       = 4,
  parameter int VEC_STRIDE = DEF_VEC_STRIDE,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  src_req,
  input  logic             mask_we,
  input  logic [NSRC-1:0]  mask_wdata,
  input  logic             irq_ack,
  input  logic             rti,
  output logic [NSRC-1:0]  mask,
  output logic [NSRC-1:0]  pending,
  output logic [NSRC-1:0]  in_service,
  output logic             irq,
  output logic [VEC_W-1:0] irq_id,
  output logic             timeout
);

  localparam int IW = idx_width(NSRC);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t          state, state_nxt;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] arb_req;
  logic [NSRC-1:0] enc_oh;
  logic [IW-1:0]   enc_idx;
  logic            enc_valid;
  logic [NSRC-1:0] cur_oh;
  logic [NSRC-1:0] pend_clr;
  logic [TW-1:0]   timer;
  logic            wd_hit;
  logic            grant, ack, expire;

  assign rise    = src_req & ~src_q;
  assign arb_req = pending & ~mask;
  assign wd_hit  = (TIMEOUT != 0) && (timer == T_LAST);

  int_prio_enc #(
    .N  (NSRC),
    .IW (IW)
  ) u_prio_enc (
    .req    (arb_req),
    .onehot (enc_oh),
    .idx    (enc_idx),
    .valid  (enc_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack       = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          grant     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          ack       = 1'b1;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (rti) begin
          state_nxt = IDLE;
        end else if (wd_hit) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A rise on the acknowledged source in the same cycle re-arms it.
  always_comb begin
    pend_clr = ack ? cur_oh : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q      <= '0;
      mask       <= '0;
      pending    <= '0;
      in_service <= '0;
      cur_oh     <= '0;
      irq        <= 1'b0;
      irq_id     <= '0;
      timeout    <= 1'b0;
      timer      <= '0;
    end else begin
      src_q   <= src_req;
      pending <= (pending & ~pend_clr) | rise;
      timeout <= expire;
      if (mask_we) mask <= mask_wdata;

      if (grant) begin
        cur_oh <= enc_oh;
        irq    <= 1'b1;
        irq_id <= VEC_W'(enc_idx) * VEC_W'(VEC_STRIDE);
      end

      if (ack) begin
        irq        <= 1'b0;
        in_service <= cur_oh;
        timer      <= '0;
      end

      if (state == SERVICE) begin
        if (rti || expire) in_service <= '0;
        else if (TIMEOUT != 0) timer <= timer + TW'(1);
      end
    end
  end

endmodule
